// File: rtl/bpm_ctrl.sv
// Session controller for the BPM datapath: sample strobe divider, valid/copied
// handshake, FWFT result FIFO, and sticky overflow/timeout flags.
module bpm_ctrl #(
  parameter int unsigned CLK_DIV         = 10,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TIMEOUT_SAMPLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  output logic                          sample_en,
  input  logic [7:0]                    dp_bpm_value,
  input  logic                          dp_bpm_valid,
  output logic                          dp_bpm_copied,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout,
  output logic                          busy
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ACK,
    S_WAIT_CLR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] to_cnt;
  logic          stop_pend;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nx;

  logic enter_run_c;
  logic capture_c;
  logic strobe_nx_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start && !stop)      state_nx = S_RUN;
      S_RUN:      if (stop_pend)           state_nx = S_IDLE;
                  else if (dp_bpm_valid)   state_nx = S_ACK;
      S_ACK:                               state_nx = S_WAIT_CLR;
      S_WAIT_CLR: if (!dp_bpm_valid)       state_nx = S_RUN;
      default:                             state_nx = S_IDLE;
    endcase
  end

  // Decoded controls; a push is allowed into a full FIFO only alongside a pop
  always_comb begin
    enter_run_c = (state == S_IDLE) && (state_nx == S_RUN);
    capture_c   = (state == S_RUN) && (state_nx == S_ACK);
    strobe_nx_c = (state_nx != S_IDLE) && (div_cnt == DW'(CLK_DIV - 1));
    full_c      = (fifo_count == CW'(FIFO_DEPTH));
    pop_c       = rd_en && (fifo_count != '0);
    push_c      = capture_c && (!full_c || pop_c);
    drop_c      = capture_c && full_c && !pop_c;
    count_nx    = fifo_count;
    if (push_c && !pop_c)      count_nx = fifo_count + CW'(1);
    else if (!push_c && pop_c) count_nx = fifo_count - CW'(1);
  end

  // Strobe divider, handshake outputs and session flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt       <= '0;
      to_cnt        <= '0;
      stop_pend     <= 1'b0;
      sample_en     <= 1'b0;
      dp_bpm_copied <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      sample_en     <= strobe_nx_c;
      dp_bpm_copied <= (state == S_ACK);
      busy          <= (state_nx != S_IDLE);

      if (state == S_IDLE || state_nx == S_IDLE || div_cnt == DW'(CLK_DIV - 1))
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);

      if (state_nx == S_IDLE)                  stop_pend <= 1'b0;
      else if (stop && state != S_IDLE)        stop_pend <= 1'b1;

      if (enter_run_c) begin
        to_cnt   <= '0;
        timeout  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (capture_c) begin
          to_cnt <= '0;
        end else if (sample_en && to_cnt != TW'(TIMEOUT_SAMPLES)) begin
          to_cnt <= to_cnt + TW'(1);
          if (to_cnt == TW'(TIMEOUT_SAMPLES - 1)) timeout <= 1'b1;
        end
        if (drop_c) overflow <= 1'b1;
      end
    end
  end

  // Result FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= dp_bpm_value;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nx;
      rd_valid   <= (count_nx != '0);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: doc/bpm_ctrl.md
# bpm_ctrl

Session controller for the BPM datapath (`DigitalBlock`). It generates the per-sample enable strobe at a fixed clock-divided rate and performs the `bpm_valid`/`bpm_copied` read handshake on the datapath's behalf. Captured BPM results are buffered in a small first-word-fall-through FIFO for the host, and the block flags overflow and no-pulse timeout conditions. It sits between the datapath and the host/register interface.

## Interface
- `CLK_DIV`, 10, clock cycles per sample strobe; legal range ≥2.
- `FIFO_DEPTH`, 4, BPM result entries; must be a power of 2, ≥2.
- `TIMEOUT_SAMPLES`, 1000, number of sample strobes without a capture before `timeout` sets.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a session from IDLE.
- `stop`  in  1  one-cycle pulse; ends the session.
- `sample_en`  out  1  one-cycle strobe to the datapath `en`.
- `dp_bpm_value`  in  8  datapath BPM result.
- `dp_bpm_valid`  in  1  datapath result-valid level.
- `dp_bpm_copied`  out  1  one-cycle acknowledge to the datapath.
- `rd_en`  in  1  host pop request.
- `rd_data`  out  8  FIFO head entry; meaningful only while `rd_valid`=1.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.
- `timeout`  out  1  sticky: `TIMEOUT_SAMPLES` strobes passed without a capture.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: FSM=IDLE; all outputs 0; FIFO empty; divider counter, timeout counter and `stop_pend` cleared.
- FSM states:
  - IDLE: `start`=1 and `stop`=0 → RUN. On entry to RUN, clear `overflow`, `timeout`, the divider and the timeout counter. FIFO contents are kept.
  - RUN: `stop_pend`=1 → IDLE. Otherwise `dp_bpm_valid`=1 → ACK, capturing `dp_bpm_value` in the same edge.
  - ACK: `dp_bpm_copied`=1 for exactly this one cycle → WAIT_CLR.
  - WAIT_CLR: when `dp_bpm_valid`=0 → RUN. This blocks double-capture of one result.
- `stop` in RUN, ACK or WAIT_CLR sets `stop_pend`. The handshake always completes, then RUN exits to IDLE. `stop_pend` clears on entering IDLE.
- `start` while `busy`=1 is ignored. `start`+`stop` together in IDLE: stay IDLE.
- Divider: counts 0..CLK_DIV-1 in every non-IDLE state and holds at 0 in IDLE. `sample_en`=1 (registered) in the cycle after the counter equals CLK_DIV-1. Sampling continues through ACK and WAIT_CLR.
- Timeout counter: increments on each `sample_en` and clears on each capture. At TIMEOUT_SAMPLES it sets `timeout` and saturates there. `timeout` stays set until the next `start` or reset.
- FIFO capture:
  - Not full: write the entry and increment `fifo_count`.
  - Full with no pop this cycle: drop the entry and set `overflow`. The handshake still runs.
- FIFO pop: `rd_en`=1 with `rd_valid`=1 advances the head. `rd_en` while empty is ignored.
- Push and pop in the same cycle: both take effect and `fifo_count` is unchanged. This holds even when the FIFO is full, with no overflow.
- Pointers wrap modulo FIFO_DEPTH.
- `rd_en` works in any state, including IDLE.

## Timing
- `start` at edge N → `busy`=1 after edge N. The first `sample_en` is high in cycle N+CLK_DIV.
- Capture path: `dp_bpm_valid` seen high at edge M →
  - the entry is visible at edge M: `rd_valid`=1 and `fifo_count` updated after edge M when the FIFO was empty;
  - `dp_bpm_copied` is high for one cycle after edge M+1.
- `rd_data` is first-word-fall-through and shows the head combinationally from the FIFO array. After a pop at edge P, the next entry is valid after edge P.
- `stop` in RUN at edge S → `busy`=0 after edge S+1, and no `sample_en` after edge S+1.
- Asserting `rst` mid-handshake drops `dp_bpm_copied` and `sample_en` immediately (asynchronously) and empties the FIFO.

## Test plan
- Reset, then `start`, CLK_DIV=10: `sample_en` pulses every 10 cycles, each one cycle wide; `busy`=1; no other outputs change.
- `dp_bpm_valid` held high with value 72 until `dp_bpm_copied`: exactly one `dp_bpm_copied` pulse; `fifo_count`=1; `rd_data`=72. Hold `dp_bpm_valid` 3 further cycles: no second capture.
- Five results 60,61,62,63,64 with no reads (depth 4): `fifo_count`=4, `overflow`=1, five `dp_bpm_copied` pulses. Reads return 60,61,62,63, then `rd_valid`=0.
- FIFO full, with `rd_en` and capture of 90 in the same cycle: `fifo_count` stays 4 and `overflow` stays 0. The last read returns 90.
- TIMEOUT_SAMPLES=5 with no results: `timeout`=1 after the 5th `sample_en`. `stop` then `start` clears it; a capture before 5 strobes keeps it 0.
- `stop` during WAIT_CLR: the handshake completes, then IDLE. `rst` pulse mid-ACK: all outputs 0 and FIFO empty.
